// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver: FSM state encoding,
// oversampling constants and the baud divider calculation.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Clocks per oversample tick, truncated (100 MHz / (115200*16) -> 54).
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial-in / byte-out bundle of the UART receiver. The master side is the
// receiver itself; the slave side is the line driver plus byte consumer.
`timescale 1ns/1ps
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_data;
    logic [DATA_BITS-1:0] data_out;
    logic                 en;

    modport master (
        input  rx_data,
        output data_out,
        output en
    );

    modport slave (
        output rx_data,
        input  data_out,
        input  en
    );
endinterface

// File: rtl/uart_receiver_baud_tick.sv
// Free-running oversample tick generator: one-clock tick every DIV clocks.
`timescale 1ns/1ps
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == CW'(DIV - 1));
            cnt_q  <= (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled: 2-FF input synchronizer, framing FSM,
// LSB-first shift register and a held output byte with a one-clock strobe.
`timescale 1ns/1ps
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.master bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Reset to 1 so a reset release never looks like a start-bit edge.
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_data;
            rx_sync_q <= rx_meta_q;
        end
    end

    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (cnt_q == CW'(MID_SAMPLE)) begin
                            cnt_q <= '0;
                            if (!rx_sync_q) begin
                                state_q   <= DATA;
                                bit_idx_q <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                // Count is anchored at mid start bit, so each wrap lands mid-bit.
                DATA: begin
                    if (tick) begin
                        if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                            cnt_q              <= '0;
                            shift_q[bit_idx_q] <= rx_sync_q;
                            if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + IW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                            cnt_q <= '0;
                            if (rx_sync_q) begin
                                data_q  <= shift_q;
                                en_q    <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                state_q <= WAIT_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_out = data_q;
    assign bus.en       = en_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven LSB first on rx_data, each
// strobed byte captured and compared against hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_receiver;

    // 625 kbaud makes DIV exactly 10 (1600 ns bits) to keep the run short.
    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 625_000;
    localparam int BIT_NS   = 1600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_receiver_if bus_if ();

    uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] rx_q[$];
    int         en_in_rst   = 0;
    int         en_wide     = 0;
    logic       en_prev     = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus_if.en) en_in_rst++;
        end else if (bus_if.en) begin
            rx_q.push_back(bus_if.data_out);
            if (en_prev) en_wide++;
        end
        en_prev = bus_if.en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive_bit(input logic v, input int ns);
        bus_if.rx_data = v;
        #(ns);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int ns);
        drive_bit(1'b0, ns);
        for (int i = 0; i < 8; i++) drive_bit(b[i], ns);
        drive_bit(stop_v, ns);
        bus_if.rx_data = 1'b1;
    endtask

    task automatic expect_one(input string tag, input logic [7:0] exp);
        logic [7:0] first;
        first = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        check({tag, "_pulses"}, rx_q.size(), 1);
        check({tag, "_data"}, first, exp);
        rx_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] seq_b[5]  = '{8'h3C, 8'h12, 8'hA5, 8'h3C, 8'h12};
    int         seq_gap[5] = '{2100, 11800, 5000, 3300, 8000};
    logic [7:0] b;

    initial begin
        bus_if.rx_data = 1'b1;
        rst            = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", bus_if.data_out, 8'h00);
        check("rst_en", bus_if.en, 1'b0);
        #4000;
        @(negedge clk) rst = 1'b0;
        #(2 * BIT_NS);

        send_frame(8'hA5, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        expect_one("first_a5", 8'hA5);

        for (int i = 0; i < 5; i++) begin
            send_frame(seq_b[i], 1'b1, BIT_NS);
            #(seq_gap[i]);
            expect_one($sformatf("seq%0d", i), seq_b[i]);
        end

        send_frame(8'h55, 1'b1, BIT_NS);
        send_frame(8'hAA, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        check("b2b_pulses", rx_q.size(), 2);
        check("b2b_first", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h55);
        check("b2b_second", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hAA);
        rx_q.delete();

        drive_bit(1'b0, 370);
        bus_if.rx_data = 1'b1;
        #(3 * BIT_NS);
        check("glitch_pulses", rx_q.size(), 0);
        send_frame(8'h3C, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        expect_one("after_glitch", 8'h3C);

        send_frame(8'h12, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        check("ferr_pulses", rx_q.size(), 0);
        check("ferr_hold", bus_if.data_out, 8'h3C);
        send_frame(8'hA5, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        expect_one("after_ferr", 8'hA5);

        // Reset held through the rest of the aborted frame.
        b = 8'hA5;
        drive_bit(1'b0, BIT_NS);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_NS);
        @(negedge clk) rst = 1'b1;
        for (int i = 4; i < 8; i++) drive_bit(b[i], BIT_NS);
        drive_bit(1'b1, BIT_NS);
        @(negedge clk);
        check("midrst_data_out", bus_if.data_out, 8'h00);
        check("midrst_en", bus_if.en, 1'b0);
        @(negedge clk) rst = 1'b0;
        #(2 * BIT_NS);
        check("midrst_pulses", rx_q.size(), 0);
        send_frame(8'h3C, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        expect_one("after_midrst", 8'h3C);

        send_frame(8'hA5, 1'b1, BIT_NS * 102 / 100);
        #(2 * BIT_NS);
        expect_one("baud_slow", 8'hA5);
        send_frame(8'h3C, 1'b1, BIT_NS * 98 / 100);
        #(2 * BIT_NS);
        expect_one("baud_fast", 8'h3C);

        drive_bit(1'b0, 20 * BIT_NS);
        check("break_pulses", rx_q.size(), 0);
        check("break_hold", bus_if.data_out, 8'h3C);
        bus_if.rx_data = 1'b1;
        #(2 * BIT_NS);
        send_frame(8'h55, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        expect_one("after_break", 8'h55);

        check("en_width", en_wide, 0);
        check("en_in_rst", en_in_rst, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
